// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters, sync decode and a single
// output register that keeps renderer colour, blanking and sync aligned.
module vga_timing #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic [2:0] red_in,
  input  logic [2:0] green_in,
  input  logic [1:0] blue_in,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       frame_start,
  output logic [7:0] frame_count,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic [2:0] vga_red,
  output logic [2:0] vga_green,
  output logic [1:0] vga_blue
);

  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] H_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0] V_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic visible;
  logic hsync_n;
  logic vsync_n;
  logic x_last;
  logic y_last;

  always_comb begin
    visible = (xpos < H_VIS) && (ypos < V_VIS);
    hsync_n = !((xpos >= HS_FIRST) && (xpos <= HS_LAST));
    vsync_n = !((ypos >= VS_FIRST) && (ypos <= VS_LAST));
    x_last  = (xpos == H_LAST);
    y_last  = (ypos == V_LAST);
  end

  // Sync and colour are decoded from the same counter values and registered
  // together, so both reach the pins one clock after the counters.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      xpos        <= '0;
      ypos        <= '0;
      frame_start <= 1'b0;
      frame_count <= '0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_red     <= '0;
      vga_green   <= '0;
      vga_blue    <= '0;
    end else begin
      if (x_last) begin
        xpos <= '0;
        if (y_last) ypos <= '0;
        else        ypos <= ypos + 10'd1;
      end else begin
        xpos <= xpos + 10'd1;
      end
      frame_start <= x_last && y_last;
      if (x_last && y_last) frame_count <= frame_count + 8'd1;
      vga_hsync <= hsync_n;
      vga_vsync <= vsync_n;
      vga_red   <= visible ? red_in   : '0;
      vga_green <= visible ? green_in : '0;
      vga_blue  <= visible ? blue_in  : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: a full-size instance for line timing and colour alignment,
// and a shrunken-raster instance (15x12) so whole frames and 256 wraps fit.
module tb_vga_timing;

  logic clk25 = 1'b0;
  logic rst   = 1'b0;
  always #20 clk25 = ~clk25;

  // Full-size instance; renderer colour is a function of xpos.
  logic [9:0] f_x, f_y;
  logic       f_fs, f_hs, f_vs;
  logic [7:0] f_fc;
  logic [2:0] f_r, f_g;
  logic [1:0] f_b;
  logic [2:0] f_rin, f_gin;
  logic [1:0] f_bin;
  assign f_rin = f_x[2:0];
  assign f_gin = f_x[5:3];
  assign f_bin = f_x[7:6];

  vga_timing dut_full (
    .clk25(clk25), .rst(rst),
    .red_in(f_rin), .green_in(f_gin), .blue_in(f_bin),
    .xpos(f_x), .ypos(f_y), .frame_start(f_fs), .frame_count(f_fc),
    .vga_hsync(f_hs), .vga_vsync(f_vs),
    .vga_red(f_r), .vga_green(f_g), .vga_blue(f_b)
  );

  // Small raster: H 8+2+3+2 = 15, V 6+2+2+2 = 12, 180 clocks per frame.
  logic [9:0] s_x, s_y;
  logic       s_fs, s_hs, s_vs;
  logic [7:0] s_fc;
  logic [2:0] s_r, s_g;
  logic [1:0] s_b;
  logic [2:0] s_rin = 3'd7;
  logic [2:0] s_gin = 3'd7;
  logic [1:0] s_bin = 2'd3;

  vga_timing #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut_small (
    .clk25(clk25), .rst(rst),
    .red_in(s_rin), .green_in(s_gin), .blue_in(s_bin),
    .xpos(s_x), .ypos(s_y), .frame_start(s_fs), .frame_count(s_fc),
    .vga_hsync(s_hs), .vga_vsync(s_vs),
    .vga_red(s_r), .vga_green(s_g), .vga_blue(s_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [9:0] fx, fy, sx, sy, pfx, pfy, psx, psy;
  logic [7:0] sfc;
  int f_hlow, f_linelen, s_vlow, s_colcnt;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk25);
    #1;
  endtask

  task automatic clear_model();
    fx = '0; fy = '0; sx = '0; sy = '0; sfc = '0;
    f_hlow = 0; f_linelen = 0; s_vlow = 0; s_colcnt = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " full xpos"}, int'(f_x), 0);
    chk({tag, " full ypos"}, int'(f_y), 0);
    chk({tag, " full frame_start"}, int'(f_fs), 0);
    chk({tag, " full frame_count"}, int'(f_fc), 0);
    chk({tag, " full hsync"}, int'(f_hs), 1);
    chk({tag, " full vsync"}, int'(f_vs), 1);
    chk({tag, " full colour"}, int'({f_r, f_g, f_b}), 0);
    chk({tag, " small xpos"}, int'(s_x), 0);
    chk({tag, " small ypos"}, int'(s_y), 0);
    chk({tag, " small frame_start"}, int'(s_fs), 0);
    chk({tag, " small frame_count"}, int'(s_fc), 0);
    chk({tag, " small hsync"}, int'(s_hs), 1);
    chk({tag, " small vsync"}, int'(s_vs), 1);
    chk({tag, " small colour"}, int'({s_r, s_g, s_b}), 0);
  endtask

  // One clock: advance the reference counters, then check registered outputs
  // against the values decoded from the pre-edge counters.
  task automatic run_cycles(input int n);
    int exp_col;
    for (int i = 0; i < n; i++) begin
      pfx = fx; pfy = fy; psx = sx; psy = sy;
      if (fx == 10'd799) begin
        fx = '0;
        fy = (fy == 10'd524) ? 10'd0 : fy + 10'd1;
      end else fx = fx + 10'd1;
      if (sx == 10'd14) begin
        sx = '0;
        if (sy == 10'd11) begin sy = '0; sfc = sfc + 8'd1; end
        else sy = sy + 10'd1;
      end else sx = sx + 10'd1;
      step();

      chk("full xpos", int'(f_x), int'(fx));
      chk("full ypos", int'(f_y), int'(fy));
      chk("full frame_start", int'(f_fs), 0);
      chk("full hsync", int'(f_hs), (pfx >= 10'd656 && pfx <= 10'd751) ? 0 : 1);
      exp_col = (pfx < 10'd640 && pfy < 10'd480) ? int'({pfx[2:0], pfx[5:3], pfx[7:6]}) : 0;
      chk("full colour align", int'({f_r, f_g, f_b}), exp_col);
      if (f_x == 10'd656) chk("hsync high at x=656", int'(f_hs), 1);
      if (f_x == 10'd657) chk("hsync low after x=656", int'(f_hs), 0);
      if (f_hs == 1'b0) f_hlow++;
      f_linelen++;
      if (fx == 10'd0) begin
        chk("hsync low clocks per line", f_hlow, 96);
        chk("line length", f_linelen, 800);
        f_hlow = 0; f_linelen = 0;
      end

      chk("small xpos", int'(s_x), int'(sx));
      chk("small ypos", int'(s_y), int'(sy));
      chk("small hsync", int'(s_hs), (psx >= 10'd10 && psx <= 10'd12) ? 0 : 1);
      chk("small vsync", int'(s_vs), (psy >= 10'd8 && psy <= 10'd9) ? 0 : 1);
      chk("small colour blank", int'({s_r, s_g, s_b}),
          (psx < 10'd8 && psy < 10'd6) ? 8'hFF : 0);
      chk("small frame_start", int'(s_fs), (psx == 10'd14 && psy == 10'd11) ? 1 : 0);
      chk("small frame_count", int'(s_fc), int'(sfc));
      if ({s_r, s_g, s_b} == 8'hFF) s_colcnt++;
      if (s_vs == 1'b0) s_vlow++;
      if (sx == 10'd0) begin
        chk("visible clocks per line", s_colcnt, (psy < 10'd6) ? 8 : 0);
        s_colcnt = 0;
      end
      if (s_fs) begin
        chk("vsync low clocks per frame", s_vlow, 30);
        s_vlow = 0;
      end
    end
  endtask

  initial begin
    #3 rst = 1'b1;
    #2 check_reset_values("power-up reset");
    @(negedge clk25);
    rst = 1'b0;
    clear_model();
    run_cycles(1);
    chk("first edge full xpos", int'(f_x), 1);
    chk("first edge small xpos", int'(s_x), 1);
    run_cycles(300);
    chk("pre-reset small vsync low", int'(s_vs), 0);
    chk("pre-reset small frame_count", int'(s_fc), 1);

    // Asynchronous reset mid-line / mid-frame, checked before any edge.
    #10 rst = 1'b1;
    #1 check_reset_values("async reset");
    @(negedge clk25);
    @(negedge clk25);
    rst = 1'b0;
    clear_model();

    run_cycles(256 * 180);
    chk("256 frames small frame_count", int'(s_fc), 0);
    chk("256 frames small frame_start", int'(s_fs), 1);
    chk("256 frames small xpos", int'(s_x), 0);
    chk("256 frames small ypos", int'(s_y), 0);
    run_cycles(1);
    chk("frame_start one cycle", int'(s_fs), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
